// File: rtl/ahb_master_pkg.sv
// Shared types for the AHB-Lite command initiator: HTRANS codes, phase state and response record.
// Pipelined address/data overlap is selected elsewhere with AHB_MASTER_PIPELINE_EN.
package ahb_master_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // Widest DATA_W the response record can carry; narrower buses zero-extend into it.
   localparam int RSP_DATA_W = 64;

   // Encoded as {a_vld, d_vld} so the flags are plain bit selects of the state.
   typedef enum logic [1:0] {
      PH_IDLE      = 2'b00,
      PH_DATA      = 2'b01,
      PH_ADDR      = 2'b10,
      PH_ADDR_DATA = 2'b11
   } phase_t;

   typedef struct packed {
      logic                  write;
      logic                  err;
      logic [RSP_DATA_W-1:0] rdata;
   } ahb_rsp_t;

endpackage

// File: rtl/ahb_wait_timer.sv
// Data-phase wait-state counter. expired is high during the last wait cycle a data phase
// may spend with HREADYOUT low; the owner terminates the phase at the end of that cycle.
module ahb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && !expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: valid/ready commands in, NONSEQ transfers out, one response each.
// Define AHB_MASTER_PIPELINE_EN to overlap the address phase of command n+1 with the data phase of n.
module ahb_lite_master
   import ahb_master_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   // Command handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
   // Responses are single-cycle rsp_valid pulses in command order with no backpressure.
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              HSEL,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [DATA_W-1:0] HWDATA,
   output logic              HREADY,
   input  logic              HREADYOUT,
   input  logic [DATA_W-1:0] HRDATA,
   output phase_t            dbg_state
);

   phase_t state_q, state_d;
   logic   a_vld, d_vld, a_nxt, d_nxt;
   logic   a_done, d_done, tmo, cmd_acc, expired;

   logic [ADDR_W-1:0] haddr_q;
   logic              hwrite_q;
   logic [DATA_W-1:0] a_wdata_q, hwdata_q;
   logic              d_write_q;
   logic              drop_pend_q, drop_write_q;
   logic              rsp_valid_q;
   ahb_rsp_t          rsp_q, rsp_d;

   assign a_vld  = state_q[1];
   assign d_vld  = state_q[0];
   assign a_done = a_vld && HREADYOUT;
   assign d_done = d_vld && HREADYOUT;
   assign tmo    = d_vld && !HREADYOUT && expired;

`ifdef AHB_MASTER_PIPELINE_EN
   assign cmd_ready = !reset && ((!a_vld && !d_vld && !drop_pend_q) || (a_vld && HREADYOUT));
`else
   assign cmd_ready = !reset && !a_vld && !d_vld && !drop_pend_q;
`endif

   assign cmd_acc = cmd_valid && cmd_ready;

   ahb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (a_done),
      .inc     (d_vld && !HREADYOUT),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= PH_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A timeout kills both phases at once; the dropped address phase is answered a cycle later.
   always_comb begin
      a_nxt = a_vld;
      d_nxt = d_vld;
      if (tmo) begin
         a_nxt = 1'b0;
         d_nxt = 1'b0;
      end else begin
         if (d_done) d_nxt = 1'b0;
         if (a_done) begin
            a_nxt = 1'b0;
            d_nxt = 1'b1;
         end
         if (cmd_acc) a_nxt = 1'b1;
      end
      state_d = phase_t'({a_nxt, d_nxt});
   end

   always_comb begin
      rsp_d = '0;
      if (drop_pend_q) begin
         rsp_d.write = drop_write_q;
         rsp_d.err   = 1'b1;
      end else if (tmo) begin
         rsp_d.write = d_write_q;
         rsp_d.err   = 1'b1;
      end else if (d_done) begin
         rsp_d.write = d_write_q;
         rsp_d.rdata = d_write_q ? '0 : RSP_DATA_W'(HRDATA);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         haddr_q      <= '0;
         hwrite_q     <= 1'b0;
         a_wdata_q    <= '0;
         hwdata_q     <= '0;
         d_write_q    <= 1'b0;
         drop_pend_q  <= 1'b0;
         drop_write_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_q        <= '0;
      end else begin
         if (cmd_acc) begin
            haddr_q   <= cmd_addr;
            hwrite_q  <= cmd_write;
            a_wdata_q <= cmd_write ? cmd_wdata : '0;
         end
         if (a_done) begin
            hwdata_q  <= a_wdata_q;
            d_write_q <= hwrite_q;
         end
         drop_pend_q <= tmo && a_vld;
         if (tmo) drop_write_q <= hwrite_q;
         rsp_valid_q <= d_done || tmo || drop_pend_q;
         rsp_q       <= rsp_d;
      end
   end

   assign HSEL      = a_vld;
   assign HTRANS    = a_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR     = haddr_q;
   assign HWRITE    = hwrite_q;
   assign HWDATA    = hwdata_q;
   assign HREADY    = HREADYOUT;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_q.write;
   assign rsp_err   = rsp_q.err;
   assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a GPIO-like slave model and a response scoreboard.
// Expectations follow AHB_MASTER_PIPELINE_EN when it is defined for the build.
module tb_ahb_lite_master;
   import ahb_master_pkg::*;

   localparam logic [31:0] A_OUT = 32'h5300_0000;
   localparam logic [31:0] A_IN  = 32'h5300_0004;
`ifdef AHB_MASTER_PIPELINE_EN
   localparam int RSP_GAP = 1;
`else
   localparam int RSP_GAP = 3;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_write, rsp_err;
   logic [31:0] rsp_rdata;
   logic        HSEL, HWRITE, HREADY, HREADYOUT;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   phase_t      dbg_state;

   ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .dbg_state(dbg_state)
   );

   // ---------------- slave model ----------------
   int          wait_cfg = 0;
   logic        loop_en = 1'b0;
   logic [31:0] gpio_in_val = '0;
   logic        slv_err = 1'b0;
   logic        slv_dp, slv_dwr;
   logic [31:0] slv_daddr, slv_out;
   int          slv_wcnt;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         slv_dp   <= 1'b0;
         slv_dwr  <= 1'b0;
         slv_wcnt <= 0;
         slv_out  <= '0;
      end else if (slv_dp && slv_wcnt != 0) begin
         slv_wcnt <= slv_wcnt - 1;
      end else begin
         if (slv_dp && slv_dwr && slv_daddr == A_OUT) slv_out <= HWDATA;
         slv_dp <= 1'b0;
         if (HSEL && HTRANS == 2'b10) begin
            slv_dp    <= 1'b1;
            slv_dwr   <= HWRITE;
            slv_daddr <= HADDR;
            slv_wcnt  <= wait_cfg;
            if (HADDR != A_OUT && HADDR != A_IN) slv_err <= 1'b1;
         end
      end
   end

   assign HREADYOUT = !(slv_dp && slv_wcnt != 0);
   assign HRDATA = (slv_dp && !slv_dwr) ?
                   ((slv_daddr == A_OUT || loop_en) ? slv_out : gpio_in_val) : '0;

   // ---------------- scoreboard ----------------
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          ns_cnt = 0;
   logic [33:0] exp_q[$];
   int          acc_cyc[$];
   int          rsp_cyc[$];
   logic [33:0] exp_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (HTRANS == 2'b10) ns_cnt <= ns_cnt + 1;
      if (rsp_valid) begin
         rsp_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
         end else begin
            exp_e = exp_q.pop_front();
            check("rsp", 64'({rsp_write, rsp_err, rsp_rdata}), 64'(exp_e));
         end
      end
   end

   function automatic int rsp_at(input int i);
      if (i < 0 || i >= rsp_cyc.size()) return -1000;
      return rsp_cyc[i];
   endfunction

   function automatic int acc_at(input int i);
      if (i < 0 || i >= acc_cyc.size()) return 1000;
      return acc_cyc[i];
   endfunction

   // ---------------- driver tasks (entered #1 after a rising edge) ----------------
   task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic err, input logic [31:0] rd);
      int   budget;
      logic acc;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      budget = 200;
      acc = 1'b0;
      while (!acc && budget > 0) begin
         @(negedge clk);
         acc = cmd_ready;
         budget--;
         if (acc) begin
            exp_q.push_back({wr, err, rd});
            acc_cyc.push_back(cyc);
         end
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      if (!acc) check("accept_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (exp_q.size() != 0 && n < budget);
      #1;
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int rb, ab, ns0, nrsp;
      logic [31:0] pat;
      reset = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = '0;
      cmd_wdata = '0;
      #1 reset = 1'b1;
      #1;
      check("rst_bus", 64'({HSEL, HTRANS, HADDR, HWRITE, HWDATA}), 64'd0);
      check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_write, rsp_rdata}), 64'd0);
      check("rst_ready", 64'(cmd_ready), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(PH_IDLE));
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      check("ready_idle", 64'(cmd_ready), 64'd1);

      // Zero-wait write.
      send(1'b1, A_OUT, 32'h0000_00A5, 1'b0, 32'h0);
      check("wr_addr_phase", 64'({HSEL, HTRANS, HWRITE, HADDR}), 64'({1'b1, 2'b10, 1'b1, A_OUT}));
      @(posedge clk);
      #1;
      check("wr_data_phase", 64'({HTRANS, HWDATA}), 64'({2'b00, 32'h0000_00A5}));
      drain(20);
      check("wr_latency", 64'(rsp_cyc[$] - acc_cyc[$]), 64'd3);
      check("wr_slave_reg", 64'(slv_out), 64'h0000_00A5);

      // Read with two wait states.
      gpio_in_val = 32'h0000_1234;
      wait_cfg = 2;
      send(1'b0, A_IN, 32'hDEAD_BEEF, 1'b0, 32'h0000_1234);
      drain(20);
      check("rd_wait_latency", 64'(rsp_cyc[$] - acc_cyc[$]), 64'd5);
      wait_cfg = 0;

      // Four back-to-back writes.
      rb = rsp_cyc.size();
      ns0 = ns_cnt;
      for (int i = 0; i < 4; i++) send(1'b1, A_OUT, 32'h11 * (i + 1), 1'b0, 32'h0);
      drain(40);
      check("burst_rsp_count", 64'(rsp_cyc.size() - rb), 64'd4);
      for (int i = 1; i < 4; i++) check("burst_gap", 64'(rsp_at(rb + i) - rsp_at(rb + i - 1)), 64'(RSP_GAP));
      check("burst_nonseq_cycles", 64'(ns_cnt - ns0), 64'd4);
      check("burst_slave_reg", 64'(slv_out), 64'h44);

      // Slave stalls 20 cycles; master gives up after 16.
      wait_cfg = 20;
      rb = rsp_cyc.size();
      ab = acc_cyc.size();
      send(1'b0, A_IN, 32'h0, 1'b1, 32'h0);
`ifdef AHB_MASTER_PIPELINE_EN
      send(1'b1, A_OUT, 32'h77, 1'b1, 32'h0);
`endif
      drain(100);
      check("tmo_latency", 64'(rsp_at(rb) - acc_at(ab)), 64'd18);
      check("tmo_bus_idle", 64'({HSEL, HTRANS}), 64'd0);
`ifdef AHB_MASTER_PIPELINE_EN
      check("tmo_second_err_gap", 64'(rsp_at(rb + 1) - rsp_at(rb)), 64'd1);
`endif
      wait_cfg = 0;
      repeat (8) @(posedge clk);
      #1;
      check("tmo_ready_after", 64'(cmd_ready), 64'd1);

      // Reset during a waited data phase.
      wait_cfg = 10;
      nrsp = rsp_cyc.size();
      send(1'b0, A_IN, 32'h0, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      exp_q.delete();
      check("mid_rst_bus", 64'({HSEL, HTRANS, HADDR, HWRITE, HWDATA}), 64'd0);
      check("mid_rst_rsp", 64'({rsp_valid, rsp_err, rsp_write, rsp_rdata}), 64'd0);
      check("mid_rst_ready", 64'(cmd_ready), 64'd0);
      wait_cfg = 0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", 64'(cmd_ready), 64'd1);
      check("post_rst_state", 64'(dbg_state), 64'(PH_IDLE));
      repeat (5) @(posedge clk);
      #1;
      check("no_rsp_after_rst", 64'(rsp_cyc.size() - nrsp), 64'd0);

      // Loopback: write a pattern, read it back through the input register.
      loop_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pat = $urandom;
         wait_cfg = $urandom_range(0, 3);
         send(1'b1, A_OUT, pat, 1'b0, 32'h0);
         send(1'b0, A_IN, 32'h0, 1'b0, pat);
      end
      drain(200);
      check("loopback_error", 64'(slv_err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Single-outstanding-command AHB-Lite initiator that turns a valid/ready command stream into single NONSEQ transfers on the AHB-Lite bus to the GPIO slave. It returns one response per command, carrying read data or an error. It sits between the bench/CPU-side command source and the `AHBGPIO` slave port, and drives `HSEL/HADDR/HTRANS/HWRITE/HWDATA/HREADY`. An optional pipelined mode overlaps the address phase of command n+1 with the data phase of command n.

## Interface
- `ADDR_W`, 32: width of `HADDR` and `cmd_addr`.
- `DATA_W`, 32: width of `HWDATA`, `HRDATA`, `cmd_wdata` and `rsp_rdata`.
- `TIMEOUT`, 16: maximum number of consecutive wait-state cycles (`HREADYOUT`=0) allowed in one data phase; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: transfer address.
- `cmd_wdata` in DATA_W: write data (ignored for reads).
- `rsp_valid` out 1: one-cycle pulse, one per accepted command; there is no backpressure.
- `rsp_write` out 1: echoes `cmd_write` of the command being responded to.
- `rsp_err` out 1: the transfer timed out or was cancelled.
- `rsp_rdata` out DATA_W: `HRDATA` captured for a read; 0 for writes and errors.
- `HSEL` out 1: slave select, high during an address phase.
- `HADDR` out ADDR_W: address-phase address.
- `HTRANS` out 2: `2'b10` NONSEQ during an address phase, otherwise `2'b00` IDLE.
- `HWRITE` out 1: address-phase direction.
- `HWDATA` out DATA_W: data-phase write data.
- `HREADY` out 1: combinational copy of `HREADYOUT` (single-slave bus).
- `HREADYOUT` in 1: slave ready.
- `HRDATA` in DATA_W: slave read data.

## Operation
- Two internal phase flags: `a_vld` (an address phase is on the bus) and `d_vld` (a data phase is on the bus). They give four states: IDLE, ADDR, ADDR_DATA, DATA.
- Accepted command: on the next cycle `a_vld`=1 and `HSEL`/`HTRANS`/`HADDR`/`HWRITE` are driven from registers. The write data is held in a one-entry data register.
- The address phase completes on an edge with `HREADYOUT`=1. The transfer then moves to the data phase: `d_vld`=1 and `HWDATA` = held data.
- The data phase completes on an edge with `HREADYOUT`=1. `rsp_valid`=1 in the next cycle, with `rsp_rdata` = `HRDATA` sampled at that edge for reads and 0 for writes.
- `cmd_ready` = !reset && !`a_vld` && !`d_vld`. When `AHB_MASTER_PIPELINE_EN` is defined it also asserts when `a_vld` && `HREADYOUT`.
- Timeout: the wait counter clears on entry to the data phase and increments on each data-phase cycle with `HREADYOUT`=0. When it reaches `TIMEOUT`:
  - The data phase is terminated with `rsp_valid`=1, `rsp_err`=1 in the next cycle.
  - A concurrent address phase is dropped (`HSEL`/`HTRANS` go IDLE) and reported with `rsp_err`=1 in the following cycle.
  - `cmd_ready` stays 0 until both responses have been issued.
- Responses are issued in command order, at most one per cycle.

## Timing
- Reset values: `HSEL`=0, `HTRANS`=IDLE, `HADDR`=0, `HWRITE`=0, `HWDATA`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_write`=0, `rsp_rdata`=0, `cmd_ready`=0 while reset is asserted. The counter and both flags clear.
- Zero-wait latency: command accepted at edge E → address phase E..E+1 → data phase E+1..E+2 → `rsp_valid` in cycle E+2..E+3 (3 cycles).
- Throughput with zero wait states: 1 command per 3 cycles without pipelining; 1 per cycle with pipelining.
- Wait states extend the data phase one cycle each. In pipelined mode they also hold the overlapping address phase, and `HADDR`/`HTRANS` stay stable.
- Reset mid-transfer drops everything immediately; no response is issued for in-flight commands.

## Configuration
- `AHB_MASTER_PIPELINE_EN` defined: address/data overlap is enabled. `cmd_ready` can assert during ADDR and ADDR_DATA.
- `AHB_MASTER_PIPELINE_EN` undefined: strictly one transfer on the bus at a time, and the ADDR_DATA state is unreachable.

## Structure
- Package `ahb_master_pkg`:
  - `HTRANS` encodings `HTRANS_IDLE`, `HTRANS_NONSEQ`.
  - `ahb_rsp_t` struct {write, err, rdata}.
  - Phase-state enum.
- Sub-module `ahb_wait_timer`: wait counter with clear, increment and `expired` output, parameterised by `TIMEOUT`.

## Test plan
- Write 0x0000_00A5 to 0x5300_0000 with zero waits → `HTRANS`=NONSEQ for 1 cycle, `HWDATA`=0xA5 next cycle, `rsp_valid`/`rsp_err`=1/0 three cycles after accept.
- Read 0x5300_0004 with `HRDATA`=0x0000_1234 and 2 wait states → data phase lasts 3 cycles, `rsp_rdata`=0x1234, `rsp_err`=0.
- 4 back-to-back writes with pipelining enabled → 4 consecutive NONSEQ cycles and 4 responses on consecutive cycles. Same stimulus with pipelining disabled → responses 3 cycles apart.
- `HREADYOUT` held 0 for 20 cycles, `TIMEOUT`=16 → `rsp_err`=1 after 16 wait cycles, bus IDLE. With pipelining enabled, a second `rsp_err` follows the next cycle.
- Assert `reset` during a waited data phase → all outputs at reset values asynchronously, no `rsp_valid`; `cmd_ready`=1 on the first cycle after release.
- Loopback run: write a random pattern to the GPIO output register and read back the input register → `rsp_rdata` equals the pattern and the loopback `error` flag stays 0.
